// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit buffer: byte width and the
// launcher FSM state encoding.
package uart_tx_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer with a separate occupancy counter. Writes are
// synchronous; the head byte is presented combinationally so the consumer
// can capture it on the same edge it pops. A write into a full buffer is
// accepted only when a pop frees a slot on the same edge; otherwise it is
// dropped and flagged with a one-cycle overflow pulse.
module byte_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointer, occupancy and overflow-flag control; pointers wrap at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= wr_en & full & ~do_rd;
    end
  end

  // Byte storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the uart core. Bytes are queued in byte_fifo
// and launched one frame at a time: IDLE pops the head when the core is free,
// START holds transmit high until the core reports busy, BUSY waits for the
// frame to finish. The IDLE busy check also covers a frame still running in
// the core after a reset of this block.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              transmit,
  output logic [BYTE_W-1:0] tx_byte,
  input  logic              is_transmitting
);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic              pop;
  logic [BYTE_W-1:0] head;

  byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // Launcher next-state logic; a pop happens only on IDLE -> START.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty && !is_transmitting) begin
          pop       = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (is_transmitting) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (!is_transmitting) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register with registered transmit and a tx_byte that moves only on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      transmit <= 1'b0;
      tx_byte  <= '0;
    end else begin
      state    <= state_nxt;
      transmit <= (state_nxt == ST_START);
      if (pop) tx_byte <= head;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based reference model predicts occupancy,
// flags and the launch handshake every cycle; accepted bytes go into a
// scoreboard that a behavioural uart core model drains as frames start.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              is_transmitting = 1'b0;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              transmit;
  logic [ADDR_W:0]   count;
  logic [7:0]        tx_byte;

  uart_tx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .overflow        (overflow),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: buffer contents, launch phase, expected outputs.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         phase     = 0;   // 0 free, 1 requesting, 2 core sending
  bit         exp_tx    = 1'b0;
  logic [7:0] exp_byte  = 8'h00;
  bit         exp_ovf   = 1'b0;
  int         accepted  = 0;
  int         ovf_seen  = 0;

  // Core model controls.
  bit hold      = 1'b0;
  bit rand_busy = 1'b0;
  int busy_len  = 20;
  int busy_cnt  = 0;
  int frames    = 0;

  always begin : ref_model
    int  pre_size;
    bit  do_pop;
    bit  acc;
    logic [7:0] b;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_q.delete();
      phase    = 0;
      exp_tx   = 1'b0;
      exp_byte = 8'h00;
      exp_ovf  = 1'b0;
    end else begin
      pre_size = mq.size();
      do_pop   = (phase == 0) && (pre_size > 0) && !is_transmitting;
      if (do_pop) begin
        b        = mq.pop_front();
        exp_byte = b;
      end
      acc = wr_en && ((pre_size < DEPTH) || do_pop);
      if (acc) begin
        mq.push_back(wr_data);
        exp_q.push_back(wr_data);
        accepted++;
      end
      exp_ovf = wr_en && !acc;
      case (phase)
        0: if (do_pop) phase = 1;
        1: if (is_transmitting) phase = 2;
        2: if (!is_transmitting) phase = 0;
        default: phase = 0;
      endcase
      exp_tx = (phase == 1);
    end
    #1;
    chk("count",    int'(count),    mq.size());
    chk("empty",    int'(empty),    int'(mq.size() == 0));
    chk("full",     int'(full),     int'(mq.size() == DEPTH));
    chk("overflow", int'(overflow), int'(exp_ovf));
    chk("transmit", int'(transmit), int'(exp_tx));
    chk("tx_byte",  int'(tx_byte),  int'(exp_byte));
    if (overflow) ovf_seen++;
  end

  // Behavioural uart core: accepts a launch, stays busy for a while, and
  // checks the launched byte against the scoreboard.
  always begin : core_model
    logic [7:0] want;
    @(posedge clk);
    #2;
    if (busy_cnt > 0) begin
      busy_cnt--;
    end else if (transmit && !is_transmitting && !hold) begin
      frames++;
      chk("frame_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        chk("frame_byte", int'(tx_byte), int'(want));
      end
      busy_cnt = rand_busy ? int'($urandom_range(1, 6)) : busy_len;
    end
    is_transmitting = hold || (busy_cnt > 0);
  end

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((!empty || transmit || is_transmitting) && n < max_cyc) begin
      @(negedge clk);
      wr_en = 1'b0;
      n++;
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_core_idle", int'(is_transmitting), 0);
  endtask

  initial begin : stimulus
    int ovf_before;
    int frames_before;
    int target;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_transmit", int'(transmit), 0);
    chk("rst_tx_byte",  int'(tx_byte),  0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_count",    int'(count),    0);
    chk("rst_empty",    int'(empty),    1);
    chk("rst_full",     int'(full),     0);
    rst = 1'b0;
    idle_cycles(2);

    // Single write and launch latency
    write_byte(8'h41);
    @(negedge clk);
    wr_en = 1'b0;
    chk("lat_empty_after_wr", int'(empty), 0);
    chk("lat_tx_not_yet", int'(transmit), 0);
    @(negedge clk);
    chk("lat_transmit", int'(transmit), 1);
    chk("lat_tx_byte", int'(tx_byte), 8'h41);
    @(negedge clk);
    chk("lat_tx_fall", int'(transmit), 0);
    wait_drain(200);

    // Burst of 16 with the core held busy, then overflow
    busy_len = 100;
    @(negedge clk);
    hold = 1'b1;
    idle_cycles(2);
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    @(negedge clk);
    wr_en = 1'b0;
    chk("burst_full", int'(full), 1);
    chk("burst_count", int'(count), 16);
    ovf_before = ovf_seen;
    write_byte(8'hAA);
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    @(negedge clk);
    chk("ovf_one_cycle", int'(overflow), 0);
    chk("ovf_pulses", ovf_seen - ovf_before, 1);

    // Release the core; write on the same edge as the first pop
    hold = 1'b0;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    chk("popwr_count", int'(count), 16);
    chk("popwr_no_ovf", int'(overflow), 0);
    chk("popwr_transmit", int'(transmit), 1);
    chk("popwr_tx_byte", int'(tx_byte), 8'h00);
    wait_drain(17 * 120);

    // Pointer wrap: 40 random bytes, interleaved with short random frames
    rand_busy     = 1'b1;
    frames_before = frames;
    target        = accepted + 40;
    n             = 0;
    while (accepted < target && n < 3000) begin
      @(negedge clk);
      wr_en   = (accepted < target) && ($urandom % 3 != 0);
      wr_data = 8'($urandom);
      n++;
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_drain(1000);
    chk("wrap_frames", frames - frames_before, 40);
    chk("wrap_empty", int'(empty), 1);

    // Reset mid-frame with 5 bytes queued
    rand_busy = 1'b0;
    busy_len  = 200;
    for (int i = 0; i < 6; i++) write_byte(8'hC0 + 8'(i));
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (!is_transmitting && n < 20) begin
      @(negedge clk);
      n++;
    end
    idle_cycles(3);
    chk("mid_busy", int'(is_transmitting), 1);
    chk("mid_queued", int'(count), 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_transmit", int'(transmit), 0);
    chk("mid_rst_count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;
    write_byte(8'h77);
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (is_transmitting && n < 300) begin
      chk("mid_no_launch", int'(transmit), 0);
      @(negedge clk);
      n++;
    end
    chk("mid_core_done", int'(is_transmitting), 0);
    wait_drain(300);

    idle_cycles(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side buffer between byte producers (echo logic, message generators) and the `uart` core. Accepts bytes in single-cycle write strobes, stores up to `DEPTH` of them, and drives the core's `transmit`/`tx_byte` handshake, launching one frame at a time. Producers never need to watch `is_transmitting` themselves.

## Interface
- `DEPTH`, 16: FIFO capacity in bytes. Must be a power of two, ≥ 2.
- `ADDR_W`, 4: log2(`DEPTH`). Must match `DEPTH`.
- `clk` input 1: master clock (100 MHz in the demo build).
- `rst` input 1: reset. Asynchronous, active-high.
- `wr_en` input 1: write strobe; one byte per cycle while high.
- `wr_data` input 8: byte to enqueue; sampled when `wr_en`=1.
- `full` output 1: FIFO holds `DEPTH` bytes.
- `empty` output 1: FIFO holds 0 bytes.
- `count` output `ADDR_W`+1: current occupancy, 0..`DEPTH`.
- `overflow` output 1: one-cycle pulse when a write is dropped.
- `transmit` output 1: launch request to the `uart` core.
- `tx_byte` output 8: byte presented to the `uart` core.
- `is_transmitting` input 1: busy flag from the `uart` core.

## Operation
- Reset values:
  - `transmit`=0, `tx_byte`=8'h00, `overflow`=0.
  - `count`=0, `empty`=1, `full`=0.
  - Read and write pointers = 0; FSM in IDLE.
- Storage: circular buffer with `ADDR_W`-bit pointers that wrap naturally at `DEPTH`. `count` is a separate `ADDR_W`+1-bit register.
- Write: when `wr_en`=1 and (`full`=0 or a pop occurs the same cycle), store `wr_data` at the write pointer, then increment the pointer.
- Overflow: when `wr_en`=1, `full`=1 and no pop occurs that cycle, drop the byte and pulse `overflow` for one cycle. Contents and `count` are unchanged.
- Pop: occurs only on the FSM transition IDLE→START. It loads `tx_byte` <= mem[read pointer] and increments the read pointer.
- Simultaneous write and pop: `count` unchanged. A write into an empty FIFO is never popped the same cycle.
- FSM states: IDLE, START, BUSY.
  - IDLE: if `empty`=0 and `is_transmitting`=0, pop and go to START. Otherwise stay.
  - START: `transmit`=1, `tx_byte` held. When `is_transmitting`=1, go to BUSY with `transmit`=0. There is no timeout; START holds indefinitely.
  - BUSY: `transmit`=0. When `is_transmitting`=0, go to IDLE.
- `tx_byte` changes only on a pop, so it is stable throughout START and BUSY.
- Reset mid-frame:
  - `transmit` drops immediately and queued bytes are discarded.
  - The `uart` core finishes any frame already in flight.
  - IDLE's `is_transmitting`=0 check prevents a launch until that frame ends.

## Timing
- `transmit` is registered. `full`, `empty` and `count` reflect state after the previous edge.
- Write-to-launch latency, with the FIFO empty and the core idle:
  - Write accepted at edge N.
  - `empty`=0 after N.
  - Pop and IDLE→START at edge N+1; `transmit`=1 and `tx_byte` valid after N+1.
- `transmit` stays high until the edge on which `is_transmitting`=1 is sampled, and falls after that edge.
- Back-to-back frames: the next pop happens on the first edge where the FSM is in IDLE and `is_transmitting`=0. That is one cycle after the BUSY→IDLE transition.
- Throughput: a 19200-baud frame is about 52 080 clocks at 100 MHz, so `DEPTH` bytes absorb a burst of `DEPTH` writes at full clock rate.

## Structure
- Package `uart_tx_pkg`: FSM state encoding (`ST_IDLE`, `ST_START`, `ST_BUSY`) and the byte width constant (8).
- Sub-module `byte_fifo`:
  - Parameterised by `DEPTH`/`ADDR_W`.
  - Ports: `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, `count`, `overflow`.
  - Synchronous write, combinational read of mem[read pointer].
- `uart_tx_fifo` contains the FSM and instantiates `byte_fifo`.

## Test plan
- **Reset then single write.** Assert reset; write 8'h41.
  - `transmit` rises exactly 1 cycle after the write edge with `tx_byte`=8'h41.
  - `transmit` falls the edge after the model raises `is_transmitting`.
- **Burst of 16 writes** (8'h00..8'h0F) at full rate with the uart model busy for 100 cycles per byte.
  - `full`=1 after the 16th write.
  - Bytes are emitted in order 00..0F.
  - `count` decrements once per frame.
- **Overflow.** Fill to 16, then write 8'hAA.
  - `overflow` pulses for 1 cycle.
  - `count` stays 16; 8'hAA is never transmitted.
  - A write on the same cycle as a pop is accepted, with no `overflow`.
- **Pointer wrap.** Pass 40 bytes through with interleaved writes and pops.
  - Output sequence equals the input sequence.
  - `empty`=1 at the end.
- **Reset mid-frame.** Assert `rst` while in BUSY with 5 bytes queued and `is_transmitting`=1.
  - `transmit`=0 immediately; `count`=0.
  - A new write is not launched until `is_transmitting` falls.
